// File: rtl/pack_pkg.sv
// Shared constants and FSM state type for the serial packet unpacker.
// Packet = preamble followed by a fixed-length byte payload, sent MSB first.
package pack_pkg;

    localparam int SIZE_BIT_PACK = 1976;
    localparam int SIZE_PREAMBLE = 32;
    localparam logic [31:0] PREAMBLE_DATA = 32'h1ACFFC1D;
    localparam logic [31:0] PREAMBLE_IDLE = 32'hE53003E2;

    // FIFO entry layout: {data[7:0], sof, eof}
    localparam int FIFO_WIDTH = 10;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        PAYLOAD = 2'd1,
        SKIP    = 2'd2,
        CHECK   = 2'd3
    } state_t;

endpackage

// File: rtl/unpack_if.sv
// Byte stream with ready/valid handshake and packet-boundary tags.
interface unpack_if;
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       valid;
    logic       ready;

    modport master (output data, sof, eof, valid, input ready);
    modport slave  (input data, sof, eof, valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Byte FIFO with registered RAM read; the output register mirrors the head entry,
// so DEPTH counts every stored byte including the one being presented.
module sync_fifo import pack_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  push,
    input  logic [FIFO_WIDTH-1:0] push_data,
    output logic                  overflow,
    unpack_if.master              rd
);

    localparam int AW = $clog2(DEPTH);

    logic [FIFO_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg, rd_addr;
    logic [AW:0]           count_reg;
    logic [FIFO_WIDTH-1:0] out_reg;
    logic                  valid_reg, overflow_reg;
    logic                  pop, full, push_ok, head_ready;

    assign pop     = valid_reg & rd.ready;
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign push_ok = push & (~full | pop);
    assign rd_addr = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    // Only entries written before this edge are readable through the registered port.
    assign head_ready = ((count_reg - (AW+1)'(pop)) != '0);

    always_ff @(posedge i_clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            out_reg      <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg   <= rd_addr;
            count_reg    <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop);
            valid_reg    <= head_ready;
            if (head_ready)
                out_reg <= mem[rd_addr];
            overflow_reg <= push & full & ~pop;
        end
    end

    assign rd.data   = out_reg[9:2];
    assign rd.sof    = out_reg[1];
    assign rd.eof    = out_reg[0];
    assign rd.valid  = valid_reg;
    assign overflow  = overflow_reg;

endmodule

// File: rtl/unpack.sv
// Serial frame synchroniser: hunts for the preamble, then flywheels on fixed-length
// packets, emitting payload bytes tagged with sof/eof through an output FIFO.
module unpack #(
    parameter int                       SIZE_BIT_PACK = pack_pkg::SIZE_BIT_PACK,
    parameter int                       SIZE_PREAMBLE = pack_pkg::SIZE_PREAMBLE,
    parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE_DATA = pack_pkg::PREAMBLE_DATA,
    parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE_IDLE = pack_pkg::PREAMBLE_IDLE,
    parameter int                       MAX_ERR       = 2,
    parameter int                       LOST_LIMIT    = 3,
    parameter int                       FIFO_DEPTH    = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_data,
    input  logic       i_valid,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_sof,
    output logic       o_eof,
    output logic       o_locked,
    output logic       o_overflow
);

    import pack_pkg::*;

    localparam int PAYLOAD_BITS = SIZE_BIT_PACK - SIZE_PREAMBLE;
    localparam int NUM_BYTES    = PAYLOAD_BITS / 8;
    localparam int CNT_W        = $clog2(PAYLOAD_BITS);
    localparam int MISS_W       = $clog2(LOST_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LAST_PAY   = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [CNT_W-1:0]  LAST_PRE   = CNT_W'(SIZE_PREAMBLE - 1);
    localparam logic [CNT_W-4:0]  LAST_BYTE  = (CNT_W-3)'(NUM_BYTES - 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOST_LIMIT);

    state_t                   state_reg, state_next;
    logic [SIZE_PREAMBLE-1:0] window_reg, window_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic [MISS_W-1:0]        miss_reg, miss_next, miss_inc;
    logic                     match_data, match_idle;
    logic                     push;
    logic [FIFO_WIDTH-1:0]    push_data;

    // Newest bit enters at the LSB; matching always includes the bit just arriving.
    assign window_next = i_valid ? {window_reg[SIZE_PREAMBLE-2:0], i_data} : window_reg;
    assign match_data  = ($countones(window_next ^ PREAMBLE_DATA) <= MAX_ERR);
    assign match_idle  = ($countones(window_next ^ PREAMBLE_IDLE) <= MAX_ERR);
    assign miss_inc    = miss_reg + MISS_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg  <= SEARCH;
            window_reg <= '0;
            cnt_reg    <= '0;
            miss_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            window_reg <= window_next;
            cnt_reg    <= cnt_next;
            miss_reg   <= miss_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        miss_next  = miss_reg;
        if (i_valid) begin
            case (state_reg)
                SEARCH: begin
                    if (match_data)
                        state_next = PAYLOAD;
                    else if (match_idle)
                        state_next = SKIP;
                end
                PAYLOAD, SKIP: begin
                    if (cnt_reg == LAST_PAY) begin
                        state_next = CHECK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (cnt_reg != LAST_PRE) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end else begin
                        cnt_next = '0;
                        if (match_data) begin
                            state_next = PAYLOAD;
                            miss_next  = '0;
                        end else if (match_idle) begin
                            state_next = SKIP;
                            miss_next  = '0;
                        end else if (miss_inc == MISS_LIMIT) begin
                            state_next = SEARCH;
                            miss_next  = '0;
                        end else begin
                            // Flywheel: assume a data packet despite the damaged preamble.
                            state_next = PAYLOAD;
                            miss_next  = miss_inc;
                        end
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    always_comb begin
        push      = i_valid && (state_reg == PAYLOAD) && (cnt_reg[2:0] == 3'd7);
        push_data = {window_next[7:0],
                     cnt_reg[CNT_W-1:3] == '0,
                     cnt_reg[CNT_W-1:3] == LAST_BYTE};
        o_locked  = (state_reg != SEARCH);
    end

    unpack_if out_if ();

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push      (push),
        .push_data (push_data),
        .overflow  (o_overflow),
        .rd        (out_if)
    );

    assign out_if.ready = i_ready;
    assign o_data       = out_if.data;
    assign o_sof        = out_if.sof;
    assign o_eof        = out_if.eof;
    assign o_valid      = out_if.valid;

endmodule

// File: tb/tb_unpack.sv
// Randomised bench for unpack: packet-level reference model predicts the byte stream.
module tb_unpack;

    localparam logic [31:0] PRE_DATA = 32'h1ACFFC1D;
    localparam logic [31:0] PRE_IDLE = 32'hE53003E2;
    localparam int NB      = 243;
    localparam int MAX_ERR = 2;
    localparam int LOST    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic dvalid = 1'b0;
    logic locked, ovf;

    unpack_if bus ();

    unpack dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_data     (din),
        .i_valid    (dvalid),
        .o_data     (bus.data),
        .o_valid    (bus.valid),
        .i_ready    (bus.ready),
        .o_sof      (bus.sof),
        .o_eof      (bus.eof),
        .o_locked   (locked),
        .o_overflow (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int ovf_cnt = 0;
    int base = 0;
    int ovf_base = 0;
    bit rand_ready = 1'b0;
    bit m_locked = 1'b0;
    int m_miss = 0;

    // Capture every accepted byte and every overflow pulse.
    always @(negedge clk) begin
        if (!rst && bus.valid && bus.ready)
            got_q.push_back({bus.data, bus.sof, bus.eof});
        if (ovf)
            ovf_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if ($urandom_range(0, 7) == 0) begin
            dvalid = 1'b0;
            din = 1'($urandom);
            if (rand_ready) bus.ready = 1'($urandom);
            tick();
        end
        dvalid = 1'b1;
        din = b;
        if (rand_ready) bus.ready = 1'($urandom);
        tick();
        dvalid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom));
    endtask

    task automatic fill_seq(output logic [7:0] p [NB]);
        for (int i = 0; i < NB; i++) p[i] = 8'(i);
    endtask

    task automatic fill_rand(output logic [7:0] p [NB]);
        for (int i = 0; i < NB; i++) p[i] = 8'($urandom);
    endtask

    task automatic fill_zero(output logic [7:0] p [NB]);
        for (int i = 0; i < NB; i++) p[i] = 8'h00;
    endtask

    function automatic logic [31:0] flip_mask(input int n);
        logic [31:0] m = '0;
        while ($countones(m) < n) m[$urandom_range(0, 31)] = 1'b1;
        return m;
    endfunction

    // Packet-level model: decides from the preamble alone whether the payload is emitted.
    function automatic bit model_preamble(input logic [31:0] pre);
        int dd = $countones(pre ^ PRE_DATA);
        int di = $countones(pre ^ PRE_IDLE);
        if (dd <= MAX_ERR) begin
            m_locked = 1'b1; m_miss = 0; return 1'b1;
        end
        if (di <= MAX_ERR) begin
            m_locked = 1'b1; m_miss = 0; return 1'b0;
        end
        if (!m_locked) return 1'b0;
        m_miss++;
        if (m_miss == LOST) begin
            m_locked = 1'b0; m_miss = 0; return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        dvalid = 1'b0;
        din = 1'b0;
        rand_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        m_locked = 1'b0;
        m_miss = 0;
        exp_q.delete();
        base = got_q.size();
        ovf_base = ovf_cnt;
    endtask

    task automatic send_packet(input logic [31:0] pre, input logic [7:0] pay [NB], input string name);
        bit emit;
        send_word(pre);
        emit = model_preamble(pre);
        total++;
        if (locked !== m_locked) begin
            bad++;
            $display("FAIL %s locked: got %0b want %0b", name, locked, m_locked);
        end
        for (int i = 0; i < NB; i++) begin
            if (emit) exp_q.push_back({pay[i], 1'(i == 0), 1'(i == NB - 1)});
            send_byte(pay[i]);
        end
        $display("packet %s: preamble=%08h payload %s", name, pre, emit ? "expected" : "not expected");
    endtask

    task automatic drain_and_check(input string name);
        int n;
        rand_ready = 1'b0;
        bus.ready = 1'b1;
        repeat (40) tick();
        n = got_q.size() - base;
        total++;
        if (n != exp_q.size()) begin
            bad++;
            $display("FAIL %s byte_count: got %0d want %0d", name, n, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            total++;
            if (got_q[base + i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s byte[%0d] {data,sof,eof}: got %03h want %03h", name, i, got_q[base + i], exp_q[i]);
                break;
            end
        end
        $display("check %s: %0d bytes received, %0d expected", name, n, exp_q.size());
        base = got_q.size();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dvalid = 1'($urandom);
            din = 1'($urandom);
            bus.ready = 1'($urandom);
            tick();
        end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset o_valid: got %b want 0", bus.valid); end
        total++; if (bus.data !== 8'h00) begin bad++; $display("FAIL reset o_data: got %02h want 00", bus.data); end
        total++; if (bus.sof !== 1'b0) begin bad++; $display("FAIL reset o_sof: got %b want 0", bus.sof); end
        total++; if (bus.eof !== 1'b0) begin bad++; $display("FAIL reset o_eof: got %b want 0", bus.eof); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset o_locked: got %b want 0", locked); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset o_overflow: got %b want 0", ovf); end
        do_reset();
    endtask

    task automatic test_single_packet();
        logic [7:0] p [NB];
        do_reset();
        bus.ready = 1'b1;
        send_random(64);
        fill_seq(p);
        send_packet(PRE_DATA, p, "single");
        drain_and_check("single");
        total++;
        if (locked !== m_locked) begin bad++; $display("FAIL single final_lock: got %b want %b", locked, m_locked); end
    endtask

    task automatic test_preamble_errors();
        logic [7:0] p [NB];
        do_reset();
        bus.ready = 1'b1;
        send_random(40);
        fill_seq(p);
        send_packet(PRE_DATA ^ flip_mask(2), p, "flip2");
        drain_and_check("flip2");
        do_reset();
        bus.ready = 1'b1;
        for (int i = 0; i < 40; i++) send_bit(1'b0);
        fill_zero(p);
        send_packet(PRE_DATA ^ flip_mask(3), p, "flip3");
        drain_and_check("flip3");
        total++;
        if (locked !== m_locked) begin bad++; $display("FAIL flip3 final_lock: got %b want %b", locked, m_locked); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p [NB];
        do_reset();
        bus.ready = 1'b1;
        send_random(50);
        rand_ready = 1'b1;
        fill_rand(p); send_packet(PRE_DATA, p, "b2b_data0");
        fill_rand(p); send_packet(PRE_IDLE, p, "b2b_idle");
        fill_rand(p); send_packet(PRE_DATA, p, "b2b_data1");
        drain_and_check("back_to_back");
        total++;
        if (ovf_cnt - ovf_base != 0) begin bad++; $display("FAIL b2b overflow_pulses: got %0d want 0", ovf_cnt - ovf_base); end
    endtask

    task automatic test_flywheel();
        logic [7:0] p [NB];
        do_reset();
        bus.ready = 1'b1;
        send_random(40);
        fill_rand(p); send_packet(PRE_DATA, p, "fly_lock");
        fill_rand(p); send_packet(PRE_DATA ^ flip_mask(8), p, "fly_miss1");
        fill_rand(p); send_packet(PRE_DATA ^ flip_mask(8), p, "fly_miss2");
        fill_zero(p); send_packet(PRE_DATA ^ flip_mask(8), p, "fly_miss3");
        drain_and_check("flywheel");
    endtask

    task automatic test_overflow();
        logic [7:0] p [NB];
        bit emit;
        do_reset();
        bus.ready = 1'b0;
        send_random(40);
        fill_seq(p);
        send_word(PRE_DATA);
        emit = model_preamble(PRE_DATA);
        for (int i = 0; i < 20; i++) send_byte(p[i]);
        tick();
        total++;
        if (bus.valid !== 1'b1 || bus.data !== p[0] || bus.sof !== 1'b1) begin
            bad++;
            $display("FAIL ovf stalled_head: got v=%b d=%02h sof=%b want v=1 d=%02h sof=1", bus.valid, bus.data, bus.sof, p[0]);
        end
        total++;
        if (ovf_cnt - ovf_base != 4) begin bad++; $display("FAIL ovf pulses: got %0d want 4", ovf_cnt - ovf_base); end
        bus.ready = 1'b1;
        for (int i = 20; i < NB; i++) send_byte(p[i]);
        for (int i = 0; i < NB; i++)
            if (emit && (i < 16 || i >= 20)) exp_q.push_back({p[i], 1'(i == 0), 1'(i == NB - 1)});
        fill_rand(p);
        send_packet(PRE_DATA, p, "after_ovf");
        drain_and_check("overflow");
        total++;
        if (ovf_cnt - ovf_base != 4) begin bad++; $display("FAIL ovf final_pulses: got %0d want 4", ovf_cnt - ovf_base); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p [NB];
        do_reset();
        bus.ready = 1'b1;
        send_random(40);
        send_word(PRE_DATA);
        send_random(1000);
        rst = 1'b1;
        tick();
        total++;
        if ({bus.valid, bus.data, bus.sof, bus.eof, locked, ovf} !== 13'b0) begin
            bad++;
            $display("FAIL midreset outputs: got v=%b d=%02h sof=%b eof=%b lock=%b ovf=%b want all 0",
                     bus.valid, bus.data, bus.sof, bus.eof, locked, ovf);
        end
        rst = 1'b0;
        m_locked = 1'b0;
        m_miss = 0;
        exp_q.delete();
        base = got_q.size();
        send_random(40);
        fill_rand(p);
        send_packet(PRE_DATA, p, "post_reset");
        drain_and_check("reset_mid");
    endtask

    initial begin
        bus.ready = 1'b0;
        test_reset();
        test_single_packet();
        test_preamble_errors();
        test_back_to_back();
        test_flywheel();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
